// File: rtl/vga_timing_generator.sv
// VGA raster timing: free-running h/v counters exposed to the renderers as x/y,
// with sync/blank/colour pins delayed to line up with the renderer pipeline.
module vga_timing_generator #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic [7:0] pixel_color,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       frame_start,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_blank_n,
  output logic       vga_sync_n
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Control bundle order: {hsync, vsync, video_on}; idle = syncs high, blanked.
  localparam logic [2:0] CTL_IDLE = 3'b110;

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_last;
  logic       v_last;
  logic       hs_raw;
  logic       vs_raw;
  logic       von_raw;
  logic [2:0] raw_ctl;
  logic [2:0] dly_ctl;

  assign h_last = (h_cnt == H_MAX);
  assign v_last = (v_cnt == V_MAX);

  // Horizontal counter advances every clock; vertical advances at end of line.
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign hs_raw  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_raw  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  assign von_raw = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign raw_ctl = {hs_raw, vs_raw, von_raw};

  assign x           = h_cnt;
  assign y           = v_cnt;
  assign video_on    = von_raw;
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);
  assign vga_sync_n  = 1'b0;

  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign dly_ctl = raw_ctl;
    end else begin : g_dly
      logic [2:0] stage [PIPE_DELAY];

      // Delay line matching renderer latency; cleared to idle so no stale sync leaks out.
      always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
          stage <= '{default: CTL_IDLE};
        end else begin
          stage[0] <= raw_ctl;
          for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign dly_ctl = stage[PIPE_DELAY-1];
    end
  endgenerate

  // Pin register: sync, blank and expanded colour all captured on the same edge.
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      vga_hs      <= dly_ctl[2];
      vga_vs      <= dly_ctl[1];
      vga_blank_n <= dly_ctl[0];
      if (dly_ctl[0]) begin
        vga_r <= {pixel_color[7:5], pixel_color[7:5], pixel_color[7:6]};
        vga_g <= {pixel_color[4:2], pixel_color[4:2], pixel_color[4:3]};
        vga_b <= {pixel_color[1:0], pixel_color[1:0], pixel_color[1:0], pixel_color[1:0]};
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

endmodule
